// File: rtl/v_pipe_update.sv
// Writer pipeline for the per-product state table: read, merge one list-modify
// command, write back; stage occupancy is exported so readers can flag busy lists.
package v_pkg;
  localparam int ENTRIES_N  = 16;
  localparam int ID_W       = 8;
  localparam int LEVEL_W    = 5;
  localparam int KEY_W      = 16;
  localparam int VOLUME_W   = 16;
  localparam int LISTSIZE_W = $clog2(ENTRIES_N + 1);

  typedef logic [ID_W-1:0]       id_t;
  typedef logic [LEVEL_W-1:0]    level_t;
  typedef logic [KEY_W-1:0]      key_t;
  typedef logic [VOLUME_W-1:0]   volume_t;
  typedef logic [LISTSIZE_W-1:0] listsize_t;

  typedef enum logic [1:0] {
    CMD_CLEAR   = 2'd0,
    CMD_ADD     = 2'd1,
    CMD_DELETE  = 2'd2,
    CMD_REPLACE = 2'd3
  } cmd_e;

  typedef struct packed {
    logic [ENTRIES_N-1:0]    vld;
    listsize_t               listsize;
    key_t [ENTRIES_N-1:0]    key;
    volume_t [ENTRIES_N-1:0] volume;
  } state_t;

  localparam int STATE_W = $bits(state_t);
endpackage

module v_pipe_update
  import v_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_upd_vld,
  input  logic [ID_W-1:0]     i_upd_prod_id,
  input  logic [1:0]          i_upd_cmd,
  input  logic [LEVEL_W-1:0]  i_upd_level,
  input  logic [KEY_W-1:0]    i_upd_key,
  input  logic [VOLUME_W-1:0] i_upd_size,
  output logic                o_state_ren,
  output logic [ID_W-1:0]     o_state_raddr,
  input  logic [STATE_W-1:0]  i_state_rdata,
  output logic                o_state_wen,
  output logic [ID_W-1:0]     o_state_waddr,
  output logic [STATE_W-1:0]  o_state_wdata,
  output logic                o_s1_upd_vld_r,
  output logic [ID_W-1:0]     o_s1_upd_prod_id_r,
  output logic                o_s2_upd_vld_r,
  output logic [ID_W-1:0]     o_s2_upd_prod_id_r,
  output logic                o_s3_upd_vld_r,
  output logic [ID_W-1:0]     o_s3_upd_prod_id_r,
  output logic                o_s4_upd_vld_r,
  output logic [ID_W-1:0]     o_s4_upd_prod_id_r,
  output logic                o_upd_vld_r,
  output logic                o_upd_error_r,
  output logic [ID_W-1:0]     o_upd_prod_id_r
);

  // S0: read issue and hazard/range classification
  logic                 s0_busy;
  logic                 s0_range;
  logic [ENTRIES_N-1:0] s0_lvl_oh;

  logic                 s1_vld_r, s2_vld_r, s3_vld_r, s4_vld_r;
  id_t                  s1_prod_id_r, s2_prod_id_r, s3_prod_id_r, s4_prod_id_r;
  cmd_e                 s1_cmd_r, s2_cmd_r;
  logic [ENTRIES_N-1:0] s1_lvl_oh_r, s2_lvl_oh_r;
  key_t                 s1_key_r, s2_key_r;
  volume_t              s1_size_r, s2_size_r;
  logic                 s1_pre_err_r, s2_pre_err_r;
  state_t               s2_rdata_r;
  logic                 s3_err_r, s4_err_r;
  state_t               s3_wdata_r;

  logic                 s2_hit;
  logic                 s2_cmd_err;
  state_t               s2_merged;

  assign o_state_ren   = i_upd_vld;
  assign o_state_raddr = i_upd_prod_id;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    s0_busy  = (s1_vld_r && s1_prod_id_r == i_upd_prod_id) ||
               (s2_vld_r && s2_prod_id_r == i_upd_prod_id) ||
               (s3_vld_r && s3_prod_id_r == i_upd_prod_id) ||
               (s4_vld_r && s4_prod_id_r == i_upd_prod_id);
    s0_range = (i_upd_level >= LEVEL_W'(ENTRIES_N));
    s0_lvl_oh = '0;
    for (int i = 0; i < ENTRIES_N; i++) begin
      s0_lvl_oh[i] = (i_upd_level == LEVEL_W'(i));
    end
  end

  // NOTE: only the valid bits are reset; payload flops load on stage valid and need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_r <= 1'b0;
      s2_vld_r <= 1'b0;
      s3_vld_r <= 1'b0;
      s4_vld_r <= 1'b0;
    end else begin
      s1_vld_r <= i_upd_vld;
      s2_vld_r <= s1_vld_r;
      s3_vld_r <= s2_vld_r;
      s4_vld_r <= s3_vld_r;
    end
  end

  always_ff @(posedge clk) begin
    if (i_upd_vld) begin
      s1_prod_id_r <= i_upd_prod_id;
      s1_cmd_r     <= cmd_e'(i_upd_cmd);
      s1_lvl_oh_r  <= s0_lvl_oh;
      s1_key_r     <= i_upd_key;
      s1_size_r    <= i_upd_size;
      s1_pre_err_r <= s0_busy | s0_range;
    end
    // RAM data is captured raw; all merge logic sits one stage later.
    if (s1_vld_r) begin
      s2_prod_id_r <= s1_prod_id_r;
      s2_cmd_r     <= s1_cmd_r;
      s2_lvl_oh_r  <= s1_lvl_oh_r;
      s2_key_r     <= s1_key_r;
      s2_size_r    <= s1_size_r;
      s2_pre_err_r <= s1_pre_err_r;
      s2_rdata_r   <= state_t'(i_state_rdata);
    end
    if (s2_vld_r) begin
      s3_prod_id_r <= s2_prod_id_r;
      s3_err_r     <= s2_pre_err_r | s2_cmd_err;
      s3_wdata_r   <= s2_merged;
    end
    if (s3_vld_r) begin
      s4_prod_id_r <= s3_prod_id_r;
      s4_err_r     <= s3_err_r;
    end
  end

  // S2 merge: listsize moves by one per ADD/DELETE, kept in step with vld by the checks.
  always_comb begin
    s2_hit     = |(s2_rdata_r.vld & s2_lvl_oh_r);
    s2_cmd_err = 1'b0;
    s2_merged  = s2_rdata_r;
    case (s2_cmd_r)
      CMD_CLEAR: begin
        s2_merged.vld      = '0;
        s2_merged.listsize = '0;
      end
      CMD_ADD: begin
        s2_cmd_err         = s2_hit;
        s2_merged.vld      = s2_rdata_r.vld | s2_lvl_oh_r;
        s2_merged.listsize = s2_rdata_r.listsize + LISTSIZE_W'(1);
        for (int i = 0; i < ENTRIES_N; i++) begin
          if (s2_lvl_oh_r[i]) begin
            s2_merged.key[i]    = s2_key_r;
            s2_merged.volume[i] = s2_size_r;
          end
        end
      end
      CMD_DELETE: begin
        s2_cmd_err         = ~s2_hit;
        s2_merged.vld      = s2_rdata_r.vld & ~s2_lvl_oh_r;
        s2_merged.listsize = s2_rdata_r.listsize - LISTSIZE_W'(1);
      end
      default: begin
        s2_cmd_err = ~s2_hit;
        for (int i = 0; i < ENTRIES_N; i++) begin
          if (s2_lvl_oh_r[i]) begin
            s2_merged.key[i]    = s2_key_r;
            s2_merged.volume[i] = s2_size_r;
          end
        end
      end
    endcase
  end

  assign o_state_wen   = s3_vld_r & ~s3_err_r & ~rst;
  assign o_state_waddr = s3_prod_id_r;
  assign o_state_wdata = s3_wdata_r;

  assign o_s1_upd_vld_r     = s1_vld_r;
  assign o_s1_upd_prod_id_r = s1_prod_id_r;
  assign o_s2_upd_vld_r     = s2_vld_r;
  assign o_s2_upd_prod_id_r = s2_prod_id_r;
  assign o_s3_upd_vld_r     = s3_vld_r;
  assign o_s3_upd_prod_id_r = s3_prod_id_r;
  assign o_s4_upd_vld_r     = s4_vld_r;
  assign o_s4_upd_prod_id_r = s4_prod_id_r;

  // The error flag is qualified so it reads 0 whenever no response is presented.
  assign o_upd_vld_r     = s4_vld_r;
  assign o_upd_error_r   = s4_vld_r & s4_err_r;
  assign o_upd_prod_id_r = s4_prod_id_r;

endmodule

// File: tb/tb_v_pipe_update.sv
// Bench for v_pipe_update: table of directed commands, hand-built hazard/reset
// sequences and random traffic, all scored against a behavioural state-table model.
module tb_v_pipe_update;
  import v_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_upd_vld;
  id_t                 i_upd_prod_id;
  logic [1:0]          i_upd_cmd;
  level_t              i_upd_level;
  key_t                i_upd_key;
  volume_t             i_upd_size;
  logic                o_state_ren;
  id_t                 o_state_raddr;
  logic [STATE_W-1:0]  i_state_rdata;
  logic                o_state_wen;
  id_t                 o_state_waddr;
  logic [STATE_W-1:0]  o_state_wdata;
  logic                o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r;
  id_t                 o_s1_upd_prod_id_r, o_s2_upd_prod_id_r, o_s3_upd_prod_id_r, o_s4_upd_prod_id_r;
  logic                o_upd_vld_r;
  logic                o_upd_error_r;
  id_t                 o_upd_prod_id_r;

  always #5 clk = ~clk;

  v_pipe_update dut (
    .clk(clk), .rst(rst),
    .i_upd_vld(i_upd_vld), .i_upd_prod_id(i_upd_prod_id), .i_upd_cmd(i_upd_cmd),
    .i_upd_level(i_upd_level), .i_upd_key(i_upd_key), .i_upd_size(i_upd_size),
    .o_state_ren(o_state_ren), .o_state_raddr(o_state_raddr), .i_state_rdata(i_state_rdata),
    .o_state_wen(o_state_wen), .o_state_waddr(o_state_waddr), .o_state_wdata(o_state_wdata),
    .o_s1_upd_vld_r(o_s1_upd_vld_r), .o_s1_upd_prod_id_r(o_s1_upd_prod_id_r),
    .o_s2_upd_vld_r(o_s2_upd_vld_r), .o_s2_upd_prod_id_r(o_s2_upd_prod_id_r),
    .o_s3_upd_vld_r(o_s3_upd_vld_r), .o_s3_upd_prod_id_r(o_s3_upd_prod_id_r),
    .o_s4_upd_vld_r(o_s4_upd_vld_r), .o_s4_upd_prod_id_r(o_s4_upd_prod_id_r),
    .o_upd_vld_r(o_upd_vld_r), .o_upd_error_r(o_upd_error_r), .o_upd_prod_id_r(o_upd_prod_id_r)
  );

  // State table RAM with one-cycle read latency; every product starts empty.
  state_t             ram [2**ID_W] = '{default: '0};
  logic [STATE_W-1:0] ram_rdata = '0;
  always @(posedge clk) begin
    if (o_state_ren) ram_rdata <= ram[o_state_raddr];
    if (o_state_wen) ram[o_state_waddr] <= state_t'(o_state_wdata);
  end
  assign i_state_rdata = ram_rdata;

  // Reference model: committed table plus the list of commands still in flight.
  typedef struct {
    int     issue;
    id_t    id;
    logic   err;
    state_t st;
  } op_t;

  op_t    pend[$];
  state_t mdl [2**ID_W] = '{default: '0};
  int     last_op [2**ID_W];
  int     cyc;
  int     n_tests = 0;
  int     n_fail  = 0;

  // Observations collected between calls to obs_clear().
  int     n_writes;
  int     obs_wen_cyc;
  int     obs_resp_cyc;
  state_t obs_wdata;
  logic   resp_log[$];
  int     wr_cyc_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_state(input string name, input logic [STATE_W-1:0] act,
                             input logic [STATE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outcome of one command against the committed table.
  function automatic op_t model_op(input id_t id, input logic [1:0] cmd, input level_t lvl,
                                   input key_t k, input volume_t sz, input int now);
    op_t    o;
    state_t s;
    logic   bad;
    int     l;
    s   = mdl[id];
    bad = 1'b0;
    if (int'(lvl) >= ENTRIES_N) begin
      bad = 1'b1;
    end else begin
      l = int'(lvl);
      case (cmd)
        2'd0: s.vld = '0;
        2'd1: if (s.vld[l]) bad = 1'b1;
              else begin s.vld[l] = 1'b1; s.key[l] = k; s.volume[l] = sz; end
        2'd2: if (!s.vld[l]) bad = 1'b1;
              else s.vld[l] = 1'b0;
        default: if (!s.vld[l]) bad = 1'b1;
                 else begin s.key[l] = k; s.volume[l] = sz; end
      endcase
    end
    s.listsize = listsize_t'($countones(s.vld));
    o.issue = now;
    o.id    = id;
    o.err   = bad | ((now - last_op[id]) <= 4);
    o.st    = s;
    return o;
  endfunction

  task automatic obs_clear();
    n_writes = 0;
    obs_wen_cyc = -1;
    obs_resp_cyc = -1;
    obs_wdata = '0;
    resp_log.delete();
    wr_cyc_log.delete();
  endtask

  // One clock cycle: drive, predict, compare at the falling edge, then commit.
  task automatic tick(input logic r, input logic v, input id_t id, input logic [1:0] cmd,
                      input level_t lvl, input key_t k, input volume_t sz);
    op_t    o;
    logic   exp_wen, exp_rv, exp_re;
    id_t    exp_waddr, exp_rid;
    state_t exp_wd;
    logic   exp_sv [1:4];
    id_t    exp_sid [1:4];
    logic   act_sv [1:4];
    id_t    act_sid [1:4];
    rst = r;
    i_upd_vld = v & ~r;
    i_upd_prod_id = id;
    i_upd_cmd = cmd;
    i_upd_level = lvl;
    i_upd_key = k;
    i_upd_size = sz;
    if (v && !r) begin
      o = model_op(id, cmd, lvl, k, sz, cyc);
      pend.push_back(o);
      last_op[id] = cyc;
    end
    exp_wen = 1'b0; exp_waddr = '0; exp_wd = '0;
    exp_rv = 1'b0; exp_re = 1'b0; exp_rid = '0;
    for (int n = 1; n <= 4; n++) begin exp_sv[n] = 1'b0; exp_sid[n] = '0; end
    foreach (pend[j]) begin
      if (pend[j].issue == cyc - 3 && !pend[j].err && !r) begin
        exp_wen = 1'b1; exp_waddr = pend[j].id; exp_wd = pend[j].st;
      end
      if (pend[j].issue == cyc - 4) begin
        exp_rv = 1'b1; exp_re = pend[j].err; exp_rid = pend[j].id;
      end
      for (int n = 1; n <= 4; n++) begin
        if (pend[j].issue == cyc - n) begin exp_sv[n] = 1'b1; exp_sid[n] = pend[j].id; end
      end
    end
    @(negedge clk);
    act_sv[1] = o_s1_upd_vld_r; act_sid[1] = o_s1_upd_prod_id_r;
    act_sv[2] = o_s2_upd_vld_r; act_sid[2] = o_s2_upd_prod_id_r;
    act_sv[3] = o_s3_upd_vld_r; act_sid[3] = o_s3_upd_prod_id_r;
    act_sv[4] = o_s4_upd_vld_r; act_sid[4] = o_s4_upd_prod_id_r;
    check("state_ren", 32'(o_state_ren), 32'(v & ~r));
    if (v && !r) check("state_raddr", 32'(o_state_raddr), 32'(id));
    check("state_wen", 32'(o_state_wen), 32'(exp_wen));
    if (exp_wen) begin
      check("state_waddr", 32'(o_state_waddr), 32'(exp_waddr));
      check_state("state_wdata", o_state_wdata, exp_wd);
    end
    check("resp_vld", 32'(o_upd_vld_r), 32'(exp_rv));
    if (exp_rv) begin
      check("resp_err", 32'(o_upd_error_r), 32'(exp_re));
      check("resp_prod_id", 32'(o_upd_prod_id_r), 32'(exp_rid));
    end
    for (int n = 1; n <= 4; n++) begin
      check($sformatf("s%0d_vld", n), 32'(act_sv[n]), 32'(exp_sv[n]));
      if (exp_sv[n]) check($sformatf("s%0d_prod_id", n), 32'(act_sid[n]), 32'(exp_sid[n]));
    end
    if (o_state_wen) begin
      n_writes++;
      obs_wen_cyc = cyc;
      obs_wdata = state_t'(o_state_wdata);
      wr_cyc_log.push_back(cyc);
    end
    if (o_upd_vld_r) begin
      obs_resp_cyc = cyc;
      resp_log.push_back(o_upd_error_r);
    end
    @(posedge clk);
    #1;
    if (exp_wen) mdl[exp_waddr] = exp_wd;
    if (r) begin
      pend.delete();
      foreach (last_op[i]) last_op[i] = -100;
    end else begin
      while (pend.size() > 0 && pend[0].issue <= cyc - 4) void'(pend.pop_front());
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, 2'd0, '0, '0, '0);
  endtask

  task automatic op(input id_t id, input logic [1:0] cmd, input level_t lvl,
                    input key_t k, input volume_t sz);
    tick(1'b0, 1'b1, id, cmd, lvl, k, sz);
  endtask

  typedef struct {
    id_t                  id;
    logic [1:0]           cmd;
    level_t               lvl;
    key_t                 key;
    volume_t              size;
    logic                 err;
    logic [ENTRIES_N-1:0] vld;
    listsize_t            ls;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int iss;

    vecs[0]  = '{8'd5,   2'd1, 5'd2,  16'h0011, 16'd100,  1'b0, 16'h0004, 5'd1};
    vecs[1]  = '{8'd5,   2'd2, 5'd2,  16'h0000, 16'd0,    1'b0, 16'h0000, 5'd0};
    vecs[2]  = '{8'd5,   2'd2, 5'd2,  16'h0000, 16'd0,    1'b1, 16'h0000, 5'd0};
    vecs[3]  = '{8'd9,   2'd1, 5'd0,  16'h000a, 16'd1,    1'b0, 16'h0001, 5'd1};
    vecs[4]  = '{8'd9,   2'd1, 5'd1,  16'h000b, 16'd2,    1'b0, 16'h0003, 5'd2};
    vecs[5]  = '{8'd9,   2'd1, 5'd5,  16'h000c, 16'd3,    1'b0, 16'h0023, 5'd3};
    vecs[6]  = '{8'd9,   2'd3, 5'd1,  16'h0022, 16'd7,    1'b0, 16'h0023, 5'd3};
    vecs[7]  = '{8'd9,   2'd1, 5'd1,  16'h0033, 16'd9,    1'b1, 16'h0000, 5'd0};
    vecs[8]  = '{8'd9,   2'd3, 5'd3,  16'h0044, 16'd9,    1'b1, 16'h0000, 5'd0};
    vecs[9]  = '{8'd9,   2'd0, 5'd0,  16'h0000, 16'd0,    1'b0, 16'h0000, 5'd0};
    vecs[10] = '{8'd9,   2'd2, 5'd0,  16'h0000, 16'd0,    1'b1, 16'h0000, 5'd0};
    vecs[11] = '{8'd5,   2'd1, 5'd16, 16'h0001, 16'd1,    1'b1, 16'h0000, 5'd0};
    vecs[12] = '{8'd5,   2'd1, 5'd31, 16'h0001, 16'd1,    1'b1, 16'h0000, 5'd0};
    vecs[13] = '{8'd5,   2'd1, 5'd15, 16'h0055, 16'hffff, 1'b0, 16'h8000, 5'd1};
    vecs[14] = '{8'd5,   2'd0, 5'd15, 16'h0000, 16'd0,    1'b0, 16'h0000, 5'd0};
    vecs[15] = '{8'd200, 2'd0, 5'd3,  16'h0000, 16'd0,    1'b0, 16'h0000, 5'd0};

    foreach (last_op[i]) last_op[i] = -100;
    rst = 1'b1;
    i_upd_vld = 1'b0; i_upd_prod_id = '0; i_upd_cmd = '0;
    i_upd_level = '0; i_upd_key = '0; i_upd_size = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_resp_vld", 32'(o_upd_vld_r), 32'd0);
    check("reset_resp_err", 32'(o_upd_error_r), 32'd0);
    check("reset_wen", 32'(o_state_wen), 32'd0);
    check("reset_stage_vld",
          32'({o_s1_upd_vld_r, o_s2_upd_vld_r, o_s3_upd_vld_r, o_s4_upd_vld_r}), 32'd0);
    @(posedge clk);
    #1;
    cyc = 0;
    obs_clear();

    // Directed table: each command runs alone through an otherwise empty pipe.
    for (int i = 0; i < 16; i++) begin
      obs_clear();
      iss = cyc;
      op(vecs[i].id, vecs[i].cmd, vecs[i].lvl, vecs[i].key, vecs[i].size);
      idle(4);
      check($sformatf("vec%0d_resp_count", i), 32'(resp_log.size()), 32'd1);
      if (resp_log.size() == 1) check($sformatf("vec%0d_err", i), 32'(resp_log[0]), 32'(vecs[i].err));
      check($sformatf("vec%0d_resp_cycle", i), 32'(obs_resp_cyc), 32'(iss + 4));
      check($sformatf("vec%0d_writes", i), 32'(n_writes), 32'(!vecs[i].err));
      if (!vecs[i].err) begin
        check($sformatf("vec%0d_write_cycle", i), 32'(obs_wen_cyc), 32'(iss + 3));
        check($sformatf("vec%0d_vld", i), 32'(obs_wdata.vld), 32'(vecs[i].vld));
        check($sformatf("vec%0d_listsize", i), 32'(obs_wdata.listsize), 32'(vecs[i].ls));
        if (vecs[i].cmd == 2'd1 || vecs[i].cmd == 2'd3) begin
          check($sformatf("vec%0d_key", i), 32'(obs_wdata.key[vecs[i].lvl]), 32'(vecs[i].key));
          check($sformatf("vec%0d_volume", i), 32'(obs_wdata.volume[vecs[i].lvl]), 32'(vecs[i].size));
        end
      end
    end

    // Same product on consecutive cycles: second is rejected busy, retry after drain works.
    obs_clear();
    op(8'd7, 2'd1, 5'd0, 16'h0070, 16'd70);
    op(8'd7, 2'd1, 5'd1, 16'h0071, 16'd71);
    idle(5);
    check("busy_resp_count", 32'(resp_log.size()), 32'd2);
    if (resp_log.size() == 2) begin
      check("busy_first_err", 32'(resp_log[0]), 32'd0);
      check("busy_second_err", 32'(resp_log[1]), 32'd1);
    end
    check("busy_writes", 32'(n_writes), 32'd1);
    obs_clear();
    op(8'd7, 2'd1, 5'd1, 16'h0071, 16'd71);
    idle(4);
    check("retry_writes", 32'(n_writes), 32'd1);
    check("retry_vld", 32'(obs_wdata.vld), 32'h0003);
    check("retry_listsize", 32'(obs_wdata.listsize), 32'd2);

    // Distinct products back to back: writes land on consecutive cycles.
    obs_clear();
    op(8'd3, 2'd1, 5'd0, 16'h0003, 16'd3);
    op(8'd4, 2'd1, 5'd0, 16'h0004, 16'd4);
    idle(5);
    check("b2b_writes", 32'(wr_cyc_log.size()), 32'd2);
    if (wr_cyc_log.size() == 2) check("b2b_write_gap", 32'(wr_cyc_log[1] - wr_cyc_log[0]), 32'd1);
    check("b2b_resp_errs", 32'(resp_log.size() == 2 && resp_log[0] == 1'b0 && resp_log[1] == 1'b0), 32'd1);

    // Reset while an op sits in S3: no write, no response, list still empty afterwards.
    obs_clear();
    op(8'd20, 2'd1, 5'd0, 16'h0020, 16'd20);
    idle(2);
    tick(1'b1, 1'b0, '0, 2'd0, '0, '0, '0);
    idle(5);
    check("rst_flight_writes", 32'(n_writes), 32'd0);
    check("rst_flight_resps", 32'(resp_log.size()), 32'd0);
    obs_clear();
    op(8'd20, 2'd1, 5'd0, 16'h0020, 16'd20);
    idle(4);
    check("rst_after_err", 32'(resp_log.size() == 1 && resp_log[0] == 1'b0), 32'd1);
    check("rst_after_listsize", 32'(obs_wdata.listsize), 32'd1);

    // Random traffic over a few products to provoke hazards and every command outcome.
    for (int i = 0; i < 3000; i++) begin
      tick(1'b0, ($urandom_range(0, 9) < 7), id_t'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), level_t'($urandom_range(0, 17)),
           key_t'($urandom), volume_t'($urandom));
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
